dual_slope_ctrl: RTL and testbench

- Conversion-sequencing FSM inside digital_top; drives analog_top directly: afe_sel, afe_reset, ref_sign, range_sel.
- Consumes comparator and saturation status from analog_top.
- Runs a dual-slope cycle: reset, auto-zero, fixed integrate of VIN, counted de-integrate against ±VREF.
- Hands a signed count plus flags to the SPI/register layer.

---
 rtl/dual_slope_ctrl_if.sv | 34 +++
 rtl/dual_slope_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_slope_ctrl_if.sv
// Signal bundle between the dual-slope sequencer and its users (analog front end, register layer).
// The slave modport is the controller's view; the master modport is the driving side's view.
interface dual_slope_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             abort_i;
  logic [2:0]       range_i;
  logic             comp_i;
  logic             sat_hi_i;
  logic             sat_lo_i;
  logic             ref_ok_i;
  logic [1:0]       afe_sel_o;
  logic             afe_reset_o;
  logic             ref_sign_o;
  logic [2:0]       range_sel_o;
  logic             busy_o;
  logic [CNT_W-1:0] result_o;
  logic             polarity_o;
  logic             ovr_o;
  logic             valid_o;

  modport slave (
    input  start_i, abort_i, range_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
    output afe_sel_o, afe_reset_o, ref_sign_o, range_sel_o, busy_o,
           result_o, polarity_o, ovr_o, valid_o
  );

  modport master (
    output start_i, abort_i, range_i, comp_i, sat_hi_i, sat_lo_i, ref_ok_i,
    input  afe_sel_o, afe_reset_o, ref_sign_o, range_sel_o, busy_o,
           result_o, polarity_o, ovr_o, valid_o
  );
endinterface

// File: rtl/dual_slope_ctrl.sv
// Dual-slope conversion sequencer: reset, auto-zero, fixed integrate, counted de-integrate.
// Build option DSC_AUTORANGE_EN: controller adapts range_sel_o from its own results.
module dual_slope_ctrl #(
  parameter int RST_CYC   = 4,
  parameter int T_AZ      = 1024,
  parameter int T_INT     = 4096,
  parameter int CNT_W     = 16,
  parameter int MAX_DEINT = 8192
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dual_slope_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REF, S_RESET, S_AZ, S_INT, S_DEINT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] AZ_LAST   = CNT_W'(T_AZ - 1);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(T_INT - 1);
  localparam logic [CNT_W-1:0] DEINT_MAX = CNT_W'(MAX_DEINT);

  logic [3:0]       sync1_q, sync2_q;
  logic             comp_s, sat_hi_s, sat_lo_s, ref_ok_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pol_q, pol_d;
  logic [1:0]       afe_sel_q, afe_sel_d;
  logic             afe_reset_q, afe_reset_d;
  logic             ref_sign_q, ref_sign_d;
  logic             busy_q, busy_d;
  logic [2:0]       range_sel_q, range_sel_d;
  logic [2:0]       range_src;
  logic [CNT_W-1:0] result_q, result_d;
  logic             polarity_q, polarity_d;
  logic             ovr_q, ovr_d;
  logic             valid_q, valid_d;
  logic             crossing;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.ref_ok_i, bus.sat_lo_i, bus.sat_hi_i, bus.comp_i};
      sync2_q <= sync1_q;
    end
  end

  assign {ref_ok_s, sat_lo_s, sat_hi_s, comp_s} = sync2_q;
  // The comparator leaves its integrate-phase level when the integrator crosses zero.
  assign crossing = (comp_s != ~pol_q);

`ifdef DSC_AUTORANGE_EN
  localparam logic [CNT_W-1:0] AR_LOW = CNT_W'(T_INT / 16);
  logic [2:0] ar_q, ar_d;
  logic       ar_init_q, ar_init_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_q      <= 3'd0;
      ar_init_q <= 1'b0;
    end else begin
      ar_q      <= ar_d;
      ar_init_q <= ar_init_d;
    end
  end

  always_comb begin
    ar_d      = ar_q;
    ar_init_d = ar_init_q;
    if (state_q == S_IDLE && bus.start_i && !ar_init_q) begin
      ar_d      = bus.range_i;
      ar_init_d = 1'b1;
    end else if (state_q == S_DONE) begin
      if (ovr_q && ar_q != 3'd7)
        ar_d = ar_q + 3'd1;
      else if (!ovr_q && result_q < AR_LOW && ar_q != 3'd0)
        ar_d = ar_q - 3'd1;
    end
  end

  assign range_src = ar_q;
`else
  assign range_src = bus.range_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pol_q       <= 1'b0;
      afe_sel_q   <= 2'b00;
      afe_reset_q <= 1'b1;
      ref_sign_q  <= 1'b0;
      busy_q      <= 1'b0;
      range_sel_q <= 3'd0;
      result_q    <= '0;
      polarity_q  <= 1'b0;
      ovr_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pol_q       <= pol_d;
      afe_sel_q   <= afe_sel_d;
      afe_reset_q <= afe_reset_d;
      ref_sign_q  <= ref_sign_d;
      busy_q      <= busy_d;
      range_sel_q <= range_sel_d;
      result_q    <= result_d;
      polarity_q  <= polarity_d;
      ovr_q       <= ovr_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pol_d       = pol_q;
    range_sel_d = range_sel_q;
    result_d    = result_q;
    polarity_d  = polarity_q;
    ovr_d       = ovr_q;

    case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_WAIT_REF;
      S_WAIT_REF: if (ref_ok_s) begin
        state_d     = S_RESET;
        cnt_d       = '0;
        range_sel_d = range_src;
      end
      S_RESET: if (cnt_q == RST_LAST) begin
        state_d = S_AZ;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_AZ: if (cnt_q == AZ_LAST) begin
        state_d = S_INT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_INT: if (cnt_q == INT_LAST) begin
        state_d = S_DEINT;
        cnt_d   = '0;
        pol_d   = ~comp_s;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_DEINT: if (crossing) begin
        state_d    = S_DONE;
        result_d   = cnt_q;
        polarity_d = pol_q;
        ovr_d      = 1'b0;
      end else if (cnt_q == DEINT_MAX) begin
        state_d    = S_DONE;
        result_d   = DEINT_MAX;
        polarity_d = pol_q;
        ovr_d      = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_INT || state_q == S_DEINT) && (sat_hi_s || sat_lo_s)) begin
      state_d    = S_DONE;
      result_d   = '1;
      polarity_d = ~sat_hi_s;
      ovr_d      = 1'b1;
    end

    // Abort outranks everything and must leave the published result untouched.
    if (bus.abort_i && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      result_d   = result_q;
      polarity_d = polarity_q;
      ovr_d      = ovr_q;
    end

    busy_d      = (state_d != S_IDLE);
    valid_d     = (state_d == S_DONE);
    afe_sel_d   = 2'b00;
    afe_reset_d = 1'b0;
    case (state_d)
      S_INT:   afe_sel_d = 2'b01;
      S_DEINT: afe_sel_d = {1'b1, ~pol_d};
      S_AZ:    afe_reset_d = 1'b0;
      default: afe_reset_d = 1'b1;
    endcase
    ref_sign_d = (state_d == S_DEINT) ? ~pol_d : ref_sign_q;
  end

  assign bus.afe_sel_o   = afe_sel_q;
  assign bus.afe_reset_o = afe_reset_q;
  assign bus.ref_sign_o  = ref_sign_q;
  assign bus.range_sel_o = range_sel_q;
  assign bus.busy_o      = busy_q;
  assign bus.result_o    = result_q;
  assign bus.polarity_o  = polarity_q;
  assign bus.ovr_o       = ovr_q;
  assign bus.valid_o     = valid_q;
endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with small phase lengths; expectations hand-derived,
// including the two-cycle lag the comparator/saturation/ref synchronisers add.
module tb_dual_slope_ctrl;
  localparam int RST_CYC   = 2;
  localparam int T_AZ      = 4;
  localparam int T_INT     = 16;
  localparam int CNT_W     = 16;
  localparam int MAX_DEINT = 40;
  localparam int BASE_LAT  = 3 + RST_CYC + T_AZ + T_INT;
  // A comparator edge driven mid-cycle is seen by the FSM two counts later.
  localparam int SYNC_LAG  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         failures = 0;
  int         cyc_cnt = 0;
  int         t0 = 0;
  logic [2:0] exp_rng = 3'd0;
  logic [2:0] prev_rng = 3'd0;
`ifdef DSC_AUTORANGE_EN
  logic [2:0] ar_reg = 3'd0;
  bit         ar_init = 1'b0;
`endif

  dual_slope_ctrl_if #(.CNT_W(CNT_W)) dif ();

  dual_slope_ctrl #(
    .RST_CYC(RST_CYC), .T_AZ(T_AZ), .T_INT(T_INT), .CNT_W(CNT_W), .MAX_DEINT(MAX_DEINT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_start();
`ifdef DSC_AUTORANGE_EN
    if (!ar_init) begin
      ar_reg  = dif.range_i;
      ar_init = 1'b1;
    end
    exp_rng = ar_reg;
`else
    exp_rng = dif.range_i;
`endif
  endtask

  task automatic model_done(input int res, input bit ovr);
`ifdef DSC_AUTORANGE_EN
    if (ovr && ar_reg != 3'd7) ar_reg = ar_reg + 3'd1;
    else if (!ovr && res < T_INT / 16 && ar_reg != 3'd0) ar_reg = ar_reg - 3'd1;
`else
    if (ovr && res < 0) exp_rng = exp_rng;
`endif
  endtask

  task automatic pulse_start();
    model_start();
    dif.start_i = 1'b1;
    t0 = cyc_cnt;
    @(negedge clk);
    dif.start_i = 1'b0;
  endtask

  task automatic wait_sel(input logic [1:0] sel, input string tag);
    int n = 0;
    while (dif.afe_sel_o !== sel && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(dif.afe_sel_o), 32'(sel));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (dif.valid_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(dif.valid_o), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_afe_sel"},   32'(dif.afe_sel_o),   32'd0);
    check_eq({tag, "_afe_reset"}, 32'(dif.afe_reset_o), 32'd1);
    check_eq({tag, "_ref_sign"},  32'(dif.ref_sign_o),  32'd0);
    check_eq({tag, "_range_sel"}, 32'(dif.range_sel_o), 32'd0);
    check_eq({tag, "_busy"},      32'(dif.busy_o),      32'd0);
    check_eq({tag, "_result"},    32'(dif.result_o),    32'd0);
    check_eq({tag, "_polarity"},  32'(dif.polarity_o),  32'd0);
    check_eq({tag, "_ovr"},       32'(dif.ovr_o),       32'd0);
    check_eq({tag, "_valid"},     32'(dif.valid_o),     32'd0);
  endtask

  // Called on the negedge where valid_o was first seen high.
  task automatic check_conv(input string tag, input int lat, input int res, input bit pol, input bit ovr);
    check_eq({tag, "_lat"},    32'(cyc_cnt - t0),    32'(lat));
    check_eq({tag, "_result"}, 32'(dif.result_o),    32'(res));
    check_eq({tag, "_pol"},    32'(dif.polarity_o),  32'(pol));
    check_eq({tag, "_ovr"},    32'(dif.ovr_o),       32'(ovr));
    check_eq({tag, "_busy"},   32'(dif.busy_o),      32'd1);
    check_eq({tag, "_range"},  32'(dif.range_sel_o), 32'(exp_rng));
    $display("conv %s: result=%0d pol=%0d ovr=%0d range=%0d lat=%0d",
             tag, dif.result_o, dif.polarity_o, dif.ovr_o, dif.range_sel_o, cyc_cnt - t0);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 32'(dif.valid_o), 32'd0);
    check_eq({tag, "_busy_drop"},  32'(dif.busy_o),  32'd0);
    model_done(res, ovr);
    prev_rng = exp_rng;
  endtask

  // Saturation flag raised mid-cycle: synced after two edges, DONE visible on the third negedge.
  task automatic sat_case(input string tag, input bit in_deint, input bit use_hi);
    pulse_start();
    wait_sel(2'b01, {tag, "_int_sel"});
    if (in_deint) wait_sel(2'b11, {tag, "_deint_sel"});
    repeat (3) @(negedge clk);
    if (use_hi) dif.sat_hi_i = 1'b1;
    else        dif.sat_lo_i = 1'b1;
    @(negedge clk);
    check_eq({tag, "_n1_valid"}, 32'(dif.valid_o), 32'd0);
    @(negedge clk);
    check_eq({tag, "_n2_valid"}, 32'(dif.valid_o), 32'd0);
    @(negedge clk);
    dif.sat_hi_i = 1'b0;
    dif.sat_lo_i = 1'b0;
    check_eq({tag, "_valid"},  32'(dif.valid_o),    32'd1);
    check_eq({tag, "_result"}, 32'(dif.result_o),   32'hFFFF);
    check_eq({tag, "_ovr"},    32'(dif.ovr_o),      32'd1);
    check_eq({tag, "_pol"},    32'(dif.polarity_o), 32'(!use_hi));
    check_eq({tag, "_range"},  32'(dif.range_sel_o), 32'(exp_rng));
    $display("conv %s: result=%0h pol=%0d ovr=%0d", tag, dif.result_o, dif.polarity_o, dif.ovr_o);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 32'(dif.valid_o), 32'd0);
    model_done(32'hFFFF, 1'b1);
    prev_rng = exp_rng;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int vcount;
    dif.start_i  = 1'b0;
    dif.abort_i  = 1'b0;
    dif.range_i  = 3'd3;
    dif.comp_i   = 1'b1;
    dif.sat_hi_i = 1'b0;
    dif.sat_lo_i = 1'b0;
    dif.ref_ok_i = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Positive input: comparator drops after 10 full de-integrate cycles.
    pulse_start();
    wait_sel(2'b01, "pos_int_sel");
    wait_sel(2'b11, "pos_deint_sel");
    check_eq("pos_ref_sign", 32'(dif.ref_sign_o), 32'd1);
    repeat (10) @(negedge clk);
    dif.comp_i = 1'b0;
    wait_valid("pos_valid", 100);
    check_conv("pos", BASE_LAT + 10 + SYNC_LAG, 10 + SYNC_LAG, 1'b0, 1'b0);

    // Negative input: comparator rises after 7 de-integrate cycles.
    pulse_start();
    wait_sel(2'b01, "neg_int_sel");
    wait_sel(2'b10, "neg_deint_sel");
    check_eq("neg_ref_sign", 32'(dif.ref_sign_o), 32'd0);
    repeat (7) @(negedge clk);
    dif.comp_i = 1'b1;
    wait_valid("neg_valid", 100);
    check_conv("neg", BASE_LAT + 7 + SYNC_LAG, 7 + SYNC_LAG, 1'b1, 1'b0);

    // No crossing at all: counter runs to MAX_DEINT.
    pulse_start();
    wait_sel(2'b11, "tmo_deint_sel");
    wait_valid("tmo_valid", 100);
    check_conv("tmo", BASE_LAT + MAX_DEINT, MAX_DEINT, 1'b0, 1'b1);

    // Comparator flips in INT cycle 15 so the synced edge lands on the first de-integrate count.
    pulse_start();
    wait_sel(2'b01, "zero_int_sel");
    repeat (14) @(negedge clk);
    dif.comp_i = 1'b0;
    wait_valid("zero_valid", 100);
    check_conv("zero", BASE_LAT, 0, 1'b0, 1'b0);
    dif.comp_i = 1'b1;
    repeat (3) @(negedge clk);

    // Abort in the middle of de-integrate.
    pulse_start();
    wait_sel(2'b11, "abt_deint_sel");
    check_eq("abt_range", 32'(dif.range_sel_o), 32'(exp_rng));
    repeat (5) @(negedge clk);
    dif.abort_i = 1'b1;
    @(negedge clk);
    dif.abort_i = 1'b0;
    check_eq("abt_busy", 32'(dif.busy_o), 32'd0);
    check_eq("abt_afe_reset", 32'(dif.afe_reset_o), 32'd1);
    check_eq("abt_afe_sel", 32'(dif.afe_sel_o), 32'd0);
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      if (dif.valid_o === 1'b1) vcount++;
      @(negedge clk);
    end
    check_eq("abt_no_valid", 32'(vcount), 32'd0);
    check_eq("abt_result_held", 32'(dif.result_o), 32'd0);
    check_eq("abt_ovr_held", 32'(dif.ovr_o), 32'd0);
    $display("conv abt: aborted, result held=%0d", dif.result_o);
    prev_rng = exp_rng;

    sat_case("sathi", 1'b0, 1'b1);
    sat_case("satlo", 1'b1, 1'b0);

    // Reference not settled: controller parks in WAIT_REF.
    dif.ref_ok_i = 1'b0;
    dif.range_i  = 3'd5;
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    check_eq("ref_busy", 32'(dif.busy_o), 32'd1);
    check_eq("ref_afe_reset", 32'(dif.afe_reset_o), 32'd1);
    check_eq("ref_hold_range", 32'(dif.range_sel_o), 32'(prev_rng));
    dif.ref_ok_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("ref_n2_range", 32'(dif.range_sel_o), 32'(prev_rng));
    @(negedge clk);
    check_eq("ref_n3_range", 32'(dif.range_sel_o), 32'(exp_rng));
    $display("conv ref: range_sel=%0d after ref_ok", dif.range_sel_o);

    // Asynchronous reset in the middle of INT.
    wait_sel(2'b01, "rst_int_sel");
    repeat (3) @(negedge clk);
    check_eq("pre_rst_result", 32'(dif.result_o), 32'hFFFF);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
`ifdef DSC_AUTORANGE_EN
    ar_init = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
